// File: rtl/imm_ext_pipe.sv
// Immediate-extension unit: extends an immediate according to a mode and queues the
// result, tag and reserved-mode flag in a DEPTH-entry FIFO behind a valid/ready handshake.
module imm_ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_W-1:0]         in_imm,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EXT_W = OUT_W - IMM_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;

    logic [OUT_W-1:0]  sext;
    entry_t            ext_d;
    logic              push, pop;

    always_comb begin
        sext       = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
        ext_d      = '0;
        ext_d.tag  = in_tag;
        unique case (in_mode)
            3'b000:  ext_d.data = {{EXT_W{1'b0}}, in_imm};
            3'b001:  ext_d.data = sext;
            3'b010:  ext_d.data = {in_imm, {EXT_W{1'b0}}};
            3'b011:  ext_d.data = sext << 2;
            3'b100:  ext_d.data = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
            3'b101:  ext_d.data = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
            default: ext_d.err  = 1'b1;
        endcase
    end

    // DEPTH is a power of two, so the level MSB alone marks a full FIFO.
    assign in_ready  = ~level_q[PTR_W];
    assign out_valid = |level_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign level     = level_q;

    // Head fields are forced to zero while empty so reset leaves the outputs clean
    // without having to clear the storage array.
    assign out_data = out_valid ? mem_q[rd_ptr_q].data : '0;
    assign out_tag  = out_valid ? mem_q[rd_ptr_q].tag  : '0;
    assign out_err  = out_valid ? mem_q[rd_ptr_q].err  : 1'b0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= ext_d;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: accepted beats queue their expected result,
// a separate monitor checks every beat the consumer takes.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [2:0]  level;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    imm_ext_pipe #(.IMM_W(16), .OUT_W(32), .TAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples at the falling edge, where the upcoming rising edge's pop is decided.
    always @(negedge clk) begin
        if (reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_beat: got data %h tag %h, expected no beat", out_data, out_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
                check("out_err", {31'd0, out_err}, {31'd0, e.err});
            end
        end
    end

    // Leaves in_valid asserted on return so consecutive calls stream back to back.
    task automatic send(input logic [15:0] imm, input logic [2:0] mode, input logic [3:0] tag,
                        input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        bit   done = 0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = exp_data;
                e.tag  = tag;
                e.err  = exp_err;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready 0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && (sb.size() != 0 || out_valid); c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", {31'd0, out_valid}, 0);
    endtask

    initial begin
        #2;
        check("rst_level", {29'd0, level}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        #11 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Modes 000..011 on a negative immediate
        out_ready = 1'b1;
        send(16'h9A49, 3'b000, 4'h1, 32'h00009A49, 1'b0);
        send(16'h9A49, 3'b001, 4'h2, 32'hFFFF9A49, 1'b0);
        send(16'h9A49, 3'b010, 4'h3, 32'h9A490000, 1'b0);
        send(16'h9A49, 3'b011, 4'h4, 32'hFFFE6924, 1'b0);
        // Byte modes and reserved modes
        send(16'h00C3, 3'b100, 4'h5, 32'hFFFFFFC3, 1'b0);
        send(16'h00C3, 3'b101, 4'h6, 32'h000000C3, 1'b0);
        send(16'h00C3, 3'b110, 4'h7, 32'h00000000, 1'b1);
        send(16'hFFFF, 3'b111, 4'h8, 32'h00000000, 1'b1);
        send(16'h7FFF, 3'b011, 4'h9, 32'h0001FFFC, 1'b0);
        drain();

        // Fill to full with the consumer stalled, fifth beat held off
        out_ready = 1'b0;
        send(16'h8001, 3'b001, 4'hA, 32'hFFFF8001, 1'b0);
        send(16'h1234, 3'b001, 4'hB, 32'h00001234, 1'b0);
        send(16'h00FF, 3'b010, 4'hC, 32'h00FF0000, 1'b0);
        send(16'h0080, 3'b100, 4'hD, 32'hFFFFFF80, 1'b0);
        check("full_level", {29'd0, level}, 4);
        check("full_in_ready", {31'd0, in_ready}, 0);
        in_imm = 16'h0042; in_mode = 3'b000; in_tag = 4'hE;
        repeat (3) @(posedge clk);
        #1;
        check("full_level_held", {29'd0, level}, 4);
        check("full_head_stable", out_data, 32'hFFFF8001);
        check("full_in_ready_held", {31'd0, in_ready}, 0);
        out_ready = 1'b1;
        send(16'h0042, 3'b000, 4'hE, 32'h00000042, 1'b0);
        drain();

        // Steady push+pop at level 2 across pointer wrap
        out_ready = 1'b0;
        send(16'h2000, 3'b000, 4'h0, 32'h00002000, 1'b0);
        send(16'h2001, 3'b000, 4'h1, 32'h00002001, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(16'h1000 + 16'(i), 3'b000, 4'(i), 32'h00001000 + 32'(i), 1'b0);
            check("steady_level", {29'd0, level}, 2);
        end
        drain();

        // Flush at level 3 while a push is offered
        out_ready = 1'b0;
        send(16'h0011, 3'b000, 4'h1, 32'h00000011, 1'b0);
        send(16'h0022, 3'b000, 4'h2, 32'h00000022, 1'b0);
        send(16'h0033, 3'b000, 4'h3, 32'h00000033, 1'b0);
        check("pre_flush_level", {29'd0, level}, 3);
        flush = 1'b1;
        in_imm = 16'h0044; in_tag = 4'h4;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush_level", {29'd0, level}, 0);
        check("flush_out_valid", {31'd0, out_valid}, 0);
        check("flush_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_dropped", {31'd0, out_valid}, 0);

        // Asynchronous reset mid-stream at level 2
        out_ready = 1'b0;
        send(16'h0055, 3'b001, 4'h5, 32'h00000055, 1'b0);
        send(16'h0066, 3'b001, 4'h6, 32'h00000066, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_level", {29'd0, level}, 2);
        #2 reset = 1'b0;
        #1;
        check("async_rst_level", {29'd0, level}, 0);
        check("async_rst_out_valid", {31'd0, out_valid}, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_tag", {28'd0, out_tag}, 0);
        check("async_rst_out_err", {31'd0, out_err}, 0);
        sb.delete();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        send(16'hBEEF, 3'b001, 4'hF, 32'hFFFFBEEF, 1'b0);
        check("post_rst_latency_valid", {31'd0, out_valid}, 1);
        check("post_rst_latency_data", out_data, 32'hFFFFBEEF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
